// File: rtl/battleship_pkg.sv
// battleship_pkg
// Shared types and constants for the battleship turn sequencing logic.
// Holds the turn FSM state enum, the game constants, and small helper
// functions for coordinate range checks and saturating accumulation.
package battleship_pkg;

  // Turn FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SCORE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [4:0] SHIP_CELLS = 5'd19;
  localparam logic [1:0] BIG_BOMBS  = 2'd2;
  localparam logic [3:0] COORD_MIN  = 4'd1;
  localparam logic [3:0] COORD_MAX  = 4'd10;
  localparam logic [6:0] SHOTS_MAX  = 7'd99;
  localparam logic [4:0] HITS_MAX   = 5'd31;

  // True when a board coordinate lies on the 1..10 playing field.
  function automatic logic coord_ok(input logic [3:0] c);
    return (c >= COORD_MIN) && (c <= COORD_MAX);
  endfunction

  // Adds this shot's hit count to the running total, clamping at HITS_MAX.
  function automatic logic [4:0] add_hits_sat(input logic [4:0] total,
                                              input logic [3:0] num);
    logic [5:0] sum;
    sum = {1'b0, total} + {2'b00, num};
    if (sum > {1'b0, HITS_MAX}) begin
      return HITS_MAX;
    end else begin
      return sum[4:0];
    end
  endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect
// Converts a level into a single registered pulse on its rising edge.
// The pulse is only produced once the level has been seen low after reset,
// so a level held high through reset release does not count as an edge.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  synchronous active-low reset
//   i_level  input level (debounced key)
//   o_pulse  one-cycle registered pulse, one cycle after the rising edge
module rise_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_level,
  output logic o_pulse
);

  logic r_prev;
  logic r_armed;
  logic r_pulse;

  // Previous-value register, low-seen arming flag and registered edge pulse.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_prev <= i_level;
      if (!i_level) begin
        r_armed <= 1'b1;
      end else begin
        r_armed <= r_armed;
      end
      r_pulse <= i_level & ~r_prev & r_armed;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/turn_controller.sv
// turn_controller
// Sequences one battleship turn per key press: captures the player's
// coordinate, validates it, lets the external combinational scorer evaluate
// the registered coordinate, and latches the result and running counters.
// Ports:
//   clock, reset_L                    clock and synchronous active-low reset
//   score_this                        key level (one request per rising edge)
//   x_in, y_in, big_in                player coordinate and big-bomb switch
//   is_hit, is_near_miss, is_miss,
//   biggest_ship, num_hit             scorer results for x_q/y_q/big_q
//   x_q, y_q, big_q                   registered shot presented to the scorer
//   hit_o, near_miss_o, miss_o,
//   biggest_o, last_hits              latched results of last accepted shot
//   something_wrong                   last request was rejected
//   big_left, total_hits, shots       game counters
//   result_valid                      one-cycle pulse when results update
//   game_over                         every ship cell has been hit
module turn_controller
  import battleship_pkg::*;
(
  input  logic       clock,
  input  logic       reset_L,
  input  logic       score_this,
  input  logic [3:0] x_in,
  input  logic [3:0] y_in,
  input  logic       big_in,
  input  logic       is_hit,
  input  logic       is_near_miss,
  input  logic       is_miss,
  input  logic [4:0] biggest_ship,
  input  logic [3:0] num_hit,
  output logic [3:0] x_q,
  output logic [3:0] y_q,
  output logic       big_q,
  output logic       hit_o,
  output logic       near_miss_o,
  output logic       miss_o,
  output logic [4:0] biggest_o,
  output logic [3:0] last_hits,
  output logic       something_wrong,
  output logic [1:0] big_left,
  output logic [4:0] total_hits,
  output logic [6:0] shots,
  output logic       result_valid,
  output logic       game_over
);

  logic       w_req;
  logic       w_reject;
  logic [4:0] w_total_next;

  state_t     r_state;
  logic [3:0] r_x_q;
  logic [3:0] r_y_q;
  logic       r_big_q;
  logic       r_hit;
  logic       r_near_miss;
  logic       r_miss;
  logic [4:0] r_biggest;
  logic [3:0] r_last_hits;
  logic       r_something_wrong;
  logic [1:0] r_big_left;
  logic [4:0] r_total_hits;
  logic [6:0] r_shots;
  logic       r_result_valid;
  logic       r_game_over;

  rise_detect u_rise_detect (
    .i_clk   (clock),
    .i_rst_n (reset_L),
    .i_level (score_this),
    .o_pulse (w_req)
  );

  // A shot is refused when off the board or asking for a bomb we no longer have.
  assign w_reject = !coord_ok(r_x_q) || !coord_ok(r_y_q) ||
                    (r_big_q && (r_big_left == 2'd0));

  assign w_total_next = add_hits_sat(r_total_hits, num_hit);

  // Turn FSM with all results and counters registered alongside it.
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      r_state           <= ST_IDLE;
      r_x_q             <= 4'd0;
      r_y_q             <= 4'd0;
      r_big_q           <= 1'b0;
      r_hit             <= 1'b0;
      r_near_miss       <= 1'b0;
      r_miss            <= 1'b0;
      r_biggest         <= 5'd0;
      r_last_hits       <= 4'd0;
      r_something_wrong <= 1'b0;
      r_big_left        <= BIG_BOMBS;
      r_total_hits      <= 5'd0;
      r_shots           <= 7'd0;
      r_result_valid    <= 1'b0;
      r_game_over       <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Pulses arriving in any other state simply fall away here.
          if (w_req) begin
            r_x_q   <= x_in;
            r_y_q   <= y_in;
            r_big_q <= big_in;
            r_state <= ST_CHECK;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (w_reject) begin
            r_something_wrong <= 1'b1;
            r_state           <= ST_IDLE;
          end else begin
            r_something_wrong <= 1'b0;
            r_state           <= ST_SCORE;
          end
        end
        ST_SCORE: begin
          r_hit          <= is_hit;
          r_near_miss    <= is_near_miss;
          r_miss         <= is_miss;
          r_biggest      <= biggest_ship;
          r_last_hits    <= num_hit;
          r_total_hits   <= w_total_next;
          r_result_valid <= 1'b1;
          if (r_shots < SHOTS_MAX) begin
            r_shots <= r_shots + 7'd1;
          end else begin
            r_shots <= SHOTS_MAX;
          end
          if (r_big_q) begin
            r_big_left <= r_big_left - 2'd1;
          end else begin
            r_big_left <= r_big_left;
          end
          if (w_total_next >= SHIP_CELLS) begin
            r_game_over <= 1'b1;
            r_state     <= ST_OVER;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_OVER: begin
          r_game_over <= 1'b1;
          r_state     <= ST_OVER;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign x_q             = r_x_q;
  assign y_q             = r_y_q;
  assign big_q           = r_big_q;
  assign hit_o           = r_hit;
  assign near_miss_o     = r_near_miss;
  assign miss_o          = r_miss;
  assign biggest_o       = r_biggest;
  assign last_hits       = r_last_hits;
  assign something_wrong = r_something_wrong;
  assign big_left        = r_big_left;
  assign total_hits      = r_total_hits;
  assign shots           = r_shots;
  assign result_valid    = r_result_valid;
  assign game_over       = r_game_over;

endmodule

// File: tb/tb_turn_controller.sv
// tb_turn_controller
// Self-checking bench for turn_controller: a hand-computed vector table,
// hand-written multi-cycle sequences, and randomized shots checked against
// a transaction-level game model.
module tb_turn_controller;

  logic       clock;
  logic       reset_L;
  logic       score_this;
  logic [3:0] x_in;
  logic [3:0] y_in;
  logic       big_in;
  logic       is_hit;
  logic       is_near_miss;
  logic       is_miss;
  logic [4:0] biggest_ship;
  logic [3:0] num_hit;
  logic [3:0] x_q;
  logic [3:0] y_q;
  logic       big_q;
  logic       hit_o;
  logic       near_miss_o;
  logic       miss_o;
  logic [4:0] biggest_o;
  logic [3:0] last_hits;
  logic       something_wrong;
  logic [1:0] big_left;
  logic [4:0] total_hits;
  logic [6:0] shots;
  logic       result_valid;
  logic       game_over;

  turn_controller dut (
    .clock           (clock),
    .reset_L         (reset_L),
    .score_this      (score_this),
    .x_in            (x_in),
    .y_in            (y_in),
    .big_in          (big_in),
    .is_hit          (is_hit),
    .is_near_miss    (is_near_miss),
    .is_miss         (is_miss),
    .biggest_ship    (biggest_ship),
    .num_hit         (num_hit),
    .x_q             (x_q),
    .y_q             (y_q),
    .big_q           (big_q),
    .hit_o           (hit_o),
    .near_miss_o     (near_miss_o),
    .miss_o          (miss_o),
    .biggest_o       (biggest_o),
    .last_hits       (last_hits),
    .something_wrong (something_wrong),
    .big_left        (big_left),
    .total_hits      (total_hits),
    .shots           (shots),
    .result_valid    (result_valid),
    .game_over       (game_over)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Game model: plain integers describing the game state.
  int m_big, m_total, m_shots, m_wrong, m_over;
  int m_hit, m_nm, m_miss, m_bs, m_last;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act != exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_big = 2; m_total = 0; m_shots = 0; m_wrong = 0; m_over = 0;
    m_hit = 0; m_nm = 0; m_miss = 0; m_bs = 0; m_last = 0;
  endtask

  // Applies one request to the game model; acc reports whether scoring happens.
  task automatic model_apply(input int x, input int y, input int big,
                             input int hit, input int nm, input int miss,
                             input int bs, input int nh, output int acc);
    acc = 0;
    if (m_over == 0) begin
      if (x < 1 || x > 10 || y < 1 || y > 10 || (big != 0 && m_big == 0)) begin
        m_wrong = 1;
      end else begin
        acc = 1;
        m_wrong = 0;
        m_shots = (m_shots + 1 > 99) ? 99 : m_shots + 1;
        m_total = (m_total + nh > 31) ? 31 : m_total + nh;
        if (big != 0) m_big = m_big - 1;
        m_hit = hit; m_nm = nm; m_miss = miss; m_bs = bs; m_last = nh;
        if (m_total >= 19) m_over = 1;
      end
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".shots"}, int'(shots), m_shots);
    chk({tag, ".total"}, int'(total_hits), m_total);
    chk({tag, ".big_left"}, int'(big_left), m_big);
    chk({tag, ".wrong"}, int'(something_wrong), m_wrong);
    chk({tag, ".over"}, int'(game_over), m_over);
    chk({tag, ".hit"}, int'(hit_o), m_hit);
    chk({tag, ".near"}, int'(near_miss_o), m_nm);
    chk({tag, ".miss"}, int'(miss_o), m_miss);
    chk({tag, ".biggest"}, int'(biggest_o), m_bs);
    chk({tag, ".last"}, int'(last_hits), m_last);
  endtask

  task automatic set_inputs(input int x, input int y, input int big,
                            input int hit, input int nm, input int miss,
                            input int bs, input int nh);
    x_in = 4'(x); y_in = 4'(y); big_in = 1'(big);
    is_hit = 1'(hit); is_near_miss = 1'(nm); is_miss = 1'(miss);
    biggest_ship = 5'(bs); num_hit = 4'(nh);
  endtask

  task automatic do_reset(input logic st);
    @(negedge clock);
    reset_L = 1'b0;
    score_this = st;
    repeat (3) @(negedge clock);
    reset_L = 1'b1;
    model_reset();
    chk_state("reset");
    chk("reset.rv", int'(result_valid), 0);
    chk("reset.xq", int'(x_q), 0);
  endtask

  // One full request: rising edge sampled at posedge n, checks at n+2, n+3, n+4.
  task automatic shot(input string tag, input int x, input int y, input int big,
                      input int hit, input int nm, input int miss,
                      input int bs, input int nh);
    int acc, old_shots, was_over;
    @(negedge clock);
    set_inputs(x, y, big, hit, nm, miss, bs, nh);
    score_this = 1'b1;
    old_shots = m_shots;
    was_over = m_over;
    model_apply(x, y, big, hit, nm, miss, bs, nh, acc);
    repeat (3) @(negedge clock);
    chk({tag, ".n2_wrong"}, int'(something_wrong), m_wrong);
    chk({tag, ".n2_shots"}, int'(shots), old_shots);
    chk({tag, ".n2_rv"}, int'(result_valid), 0);
    @(negedge clock);
    chk({tag, ".n3_rv"}, int'(result_valid), acc);
    chk_state({tag, ".n3"});
    if (was_over == 0) begin
      chk({tag, ".xq"}, int'(x_q), x);
      chk({tag, ".yq"}, int'(y_q), y);
    end else begin
      chk({tag, ".over_rv"}, int'(result_valid), 0);
    end
    score_this = 1'b0;
    @(negedge clock);
    chk({tag, ".n4_rv"}, int'(result_valid), 0);
    @(negedge clock);
  endtask

  typedef struct {
    int x, y, big, hit, nm, miss, bs, nh;
    int e_wrong, e_big, e_total, e_shots;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int acc;
    reset_L = 1'b0;
    score_this = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();

    //          x   y  big hit nm mis bs  nh  wrong big total shots
    vecs[0] = '{7,  6,  0,  1, 0, 0,  1,  1,  0,    2,  1,    1};
    vecs[1] = '{0,  5,  0,  1, 0, 0,  2,  2,  1,    2,  1,    1};
    vecs[2] = '{11, 3,  0,  1, 0, 0,  2,  2,  1,    2,  1,    1};
    vecs[3] = '{3,  2,  1,  1, 0, 0,  4,  3,  0,    1,  4,    2};
    vecs[4] = '{3,  2,  1,  0, 1, 0,  0,  0,  0,    0,  4,    3};
    vecs[5] = '{3,  2,  1,  1, 0, 0,  8,  2,  1,    0,  4,    3};
    vecs[6] = '{10, 10, 0,  0, 0, 1,  0,  0,  0,    0,  4,    4};
    vecs[7] = '{1,  1,  0,  1, 0, 0, 16,  5,  0,    0,  9,    5};

    do_reset(1'b0);
    repeat (2) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      shot($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].big,
           vecs[i].hit, vecs[i].nm, vecs[i].miss, vecs[i].bs, vecs[i].nh);
      chk($sformatf("vec%0d.tbl_wrong", i), int'(something_wrong), vecs[i].e_wrong);
      chk($sformatf("vec%0d.tbl_big", i), int'(big_left), vecs[i].e_big);
      chk($sformatf("vec%0d.tbl_total", i), int'(total_hits), vecs[i].e_total);
      chk($sformatf("vec%0d.tbl_shots", i), int'(shots), vecs[i].e_shots);
    end

    // Level held for 50 cycles counts once.
    do_reset(1'b0);
    @(negedge clock);
    set_inputs(5, 5, 0, 1, 0, 0, 1, 2);
    score_this = 1'b1;
    model_apply(5, 5, 0, 1, 0, 0, 1, 2, acc);
    repeat (50) @(negedge clock);
    score_this = 1'b0;
    repeat (3) @(negedge clock);
    chk_state("held50");
    chk("held50.shots1", int'(shots), 1);

    // Second rising edge lands while the first shot is scoring.
    @(negedge clock);
    set_inputs(4, 4, 0, 1, 0, 0, 2, 1);
    score_this = 1'b1;
    model_apply(4, 4, 0, 1, 0, 0, 2, 1, acc);
    @(negedge clock);
    score_this = 1'b0;
    @(negedge clock);
    score_this = 1'b1;
    repeat (2) @(negedge clock);
    chk("dbl.rv", int'(result_valid), 1);
    repeat (3) @(negedge clock);
    score_this = 1'b0;
    repeat (4) @(negedge clock);
    chk_state("dbl");
    chk("dbl.shots2", int'(shots), 2);

    // Key held through reset release: nothing until it falls and rises.
    set_inputs(6, 6, 0, 1, 0, 0, 1, 1);
    do_reset(1'b1);
    repeat (6) @(negedge clock);
    chk("hold_rst.shots", int'(shots), 0);
    chk("hold_rst.xq", int'(x_q), 0);
    score_this = 1'b0;
    @(negedge clock);
    shot("after_hold", 6, 6, 0, 1, 0, 0, 1, 1);

    // Reset during SCORE aborts the shot.
    do_reset(1'b0);
    @(negedge clock);
    set_inputs(2, 3, 1, 1, 0, 0, 4, 3);
    score_this = 1'b1;
    repeat (3) @(negedge clock);
    reset_L = 1'b0;
    @(negedge clock);
    chk("abort.rv_a", int'(result_valid), 0);
    reset_L = 1'b1;
    score_this = 1'b0;
    @(negedge clock);
    chk("abort.rv_b", int'(result_valid), 0);
    model_reset();
    chk_state("abort");

    // Accumulate to 19 hits, then requests are ignored until reset.
    do_reset(1'b0);
    shot("go1", 5, 5, 0, 1, 0, 0, 16, 9);
    shot("go2", 6, 6, 0, 1, 0, 0, 16, 9);
    chk("go2.over", int'(game_over), 0);
    shot("go3", 1, 10, 0, 1, 0, 0, 1, 1);
    chk("go3.over", int'(game_over), 1);
    shot("go4", 2, 2, 1, 0, 0, 1, 0, 0);
    shot("go5", 0, 2, 0, 1, 0, 0, 1, 2);
    chk("go5.shots", int'(shots), 3);
    do_reset(1'b0);

    // Randomized shots against the game model.
    for (int k = 0; k < 80; k++) begin
      int rx, ry, rb, rh, rnh;
      if (m_over != 0) do_reset(1'b0);
      rx = int'($urandom_range(0, 12));
      ry = int'($urandom_range(0, 12));
      rb = ($urandom_range(0, 2) == 0) ? 1 : 0;
      rh = int'($urandom_range(0, 2));
      rnh = int'($urandom_range(0, 4));
      shot($sformatf("rnd%0d", k), rx, ry, rb,
           (rh == 0) ? 1 : 0, (rh == 1) ? 1 : 0, (rh == 2) ? 1 : 0,
           int'($urandom_range(0, 31)), rnh);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/turn_controller.md
TURN_CONTROLLER -- requirements
Module: turn_controller

Interface
REQ-001 The block SHALL run on one clock and use a synchronous, active-low reset: clock, reset_L.
REQ-002 clock  in  1  rising-edge system clock.
REQ-003 reset_L  in  1  synchronous active-low reset, sampled on the clock edge.
REQ-004 score_this  in  1  active-high level from the debounced, inverted KEY[0].
REQ-005 x_in, y_in  in  4 each  player coordinate switches.
REQ-006 big_in  in  1  big-bomb request switch.
REQ-007 is_hit, is_near_miss, is_miss  in  1 each  combinational scorer results for the presented shot.
REQ-008 biggest_ship  in  5  one-hot biggest ship hit, from the scorer.
REQ-009 num_hit  in  4  cells hit this shot (0..9), from the scorer.
REQ-010 x_q, y_q  out  4 each  registered coordinate driven to the scorer.
REQ-011 big_q  out  1  registered big flag driven to the scorer.
REQ-012 hit_o, near_miss_o, miss_o  out  1 each  latched result of the last accepted shot.
REQ-013 biggest_o  out  5  latched biggest_ship.
REQ-014 last_hits  out  4  latched num_hit.
REQ-015 something_wrong  out  1  last request was rejected.
REQ-016 big_left  out  2  big bombs remaining.
REQ-017 total_hits  out  5  accumulated hits.
REQ-018 shots  out  7  accepted shots.
REQ-019 result_valid  out  1  one-cycle pulse when results update.
REQ-020 game_over  out  1  all ship cells counted.

Function
REQ-021 The block SHALL detect a request as score_this being 1 in this cycle and 0 in the previous cycle; a held level SHALL produce one request only.
REQ-022 The FSM SHALL have the states IDLE, CHECK, SCORE and OVER.
REQ-023 In IDLE, a request SHALL load x_in, y_in and big_in into x_q, y_q and big_q, and the FSM SHALL go to CHECK.
REQ-024 CHECK SHALL reject the shot if x_q or y_q lies outside 1..10, or if big_q=1 with big_left=0.
REQ-025 On rejection, the block SHALL set something_wrong=1 and return to IDLE, with results and counters unchanged.
REQ-026 On acceptance, the block SHALL clear something_wrong and go to SCORE.
REQ-027 SCORE SHALL capture the scorer inputs into hit_o, near_miss_o, miss_o, biggest_o and last_hits.
REQ-028 SCORE SHALL also:
- increment shots, saturating at 99;
- add num_hit to total_hits, saturating at 31;
- decrement big_left if big_q=1.
REQ-029 result_valid SHALL be 1 for the single cycle after SCORE.
REQ-030 Latency: for a request edge sampled at cycle n, outputs SHALL update at n+3; a rejection SHALL be visible at n+2.
REQ-031 Request edges arriving in CHECK or SCORE SHALL be discarded, not queued.
REQ-032 After SCORE, if the new total_hits >= SHIP_CELLS (19), the FSM SHALL enter OVER; otherwise it SHALL enter IDLE.
REQ-033 OVER SHALL hold game_over=1 and ignore all requests; only reset SHALL exit it.
REQ-034 Latched results SHALL hold between shots.
REQ-035 something_wrong SHALL persist until the next accepted shot, or until reset.

Reset
REQ-036 While reset_L=0 at a clock edge, the state SHALL become IDLE.
REQ-037 Reset SHALL set big_left=2 and every other output and register to 0, including the previous-score_this register.
REQ-038 Reset asserted mid-shot (CHECK or SCORE) SHALL abort the shot with no counter update.
REQ-039 If score_this is held high through reset release, no request SHALL occur until score_this falls and rises again.

Structure
REQ-040 The package battleship_pkg SHALL hold:
- the state enum;
- SHIP_CELLS=19;
- BIG_BOMBS=2;
- COORD_MIN=1 and COORD_MAX=10.
REQ-041 The rise detection SHALL be one sub-module, rise_detect, containing the previous-value register and the pulse output.
REQ-042 The scorer SHALL remain external and combinational; this block SHALL only sequence it and register its results.

Verification
REQ-043 Shot at (7,6), big=0, with scorer is_hit=1, num_hit=1, biggest=00001 -> result_valid at n+3; hit_o=1, total_hits=1, shots=1, big_left=2.
REQ-044 Request at (0,5) or (11,3) -> something_wrong=1 at n+2; shots, total_hits and results unchanged. The next valid shot clears it.
REQ-045 Three big shots at (3,2) -> big_left 2, 1, then 0. The third SHALL be rejected with something_wrong=1 and big_left staying 0.
REQ-046 score_this held high for 50 cycles -> exactly one shot counted. A second rising edge inside CHECK/SCORE -> ignored.
REQ-047 Shots accumulating num_hit to 19 -> game_over=1, state OVER. Further requests change nothing until reset_L=0, after which big_left=2 and the counters are 0.
REQ-048 reset_L=0 during SCORE -> shots stays 0 and result_valid never pulses.
